// File: rtl/letc_pkg.sv
// Shared LIMP memory-interface types and the arbiter state encoding.
// Request is 71 bits and response is 34 bits.
package letc_pkg;

   typedef enum logic [2:0] {
      LIMP_READ      = 3'd0,
      LIMP_WRITE     = 3'd1,
      LIMP_AMO_READ  = 3'd2,
      LIMP_AMO_WRITE = 3'd3
   } limp_cmd_e;

   typedef enum logic [1:0] {
      LIMP_BYTE = 2'd0,
      LIMP_HALF = 2'd1,
      LIMP_WORD = 2'd2
   } limp_size_e;

   typedef struct packed {
      logic        valid;
      limp_cmd_e   cmd;
      limp_size_e  size;
      logic [32:0] addr;
      logic [31:0] wdata;
   } limp_req_s;

   typedef struct packed {
      logic        ready;
      logic        illegal;
      logic [31:0] rdata;
   } limp_rsp_s;

   typedef enum logic [1:0] {
      LIMP_ARB_IDLE,
      LIMP_ARB_BUSY,
      LIMP_ARB_LOCK
   } limp_arb_state_e;

   localparam int LIMP_MAX_PORTS = 16;

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_prio_pick #(
   parameter  int NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [IDX_W-1:0]     idx,
   output logic                 any
);

   function automatic logic [IDX_W-1:0] wrap(input int v);
      return IDX_W'(v % NUM_PORTS);
   endfunction

   // Scan from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
         if (req[wrap(int'(ptr) + off)]) begin
            idx = wrap(int'(ptr) + off);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/limp_arbiter.sv
// N-to-1 LIMP arbiter: round-robin grant, one-cycle arbitration bubble,
// and a post-AMO_READ lock reserving the target for the same port.
module limp_arbiter
   import letc_pkg::*;
#(
   parameter  int NUM_PORTS    = 4,
   parameter  int LOCK_TIMEOUT = 16,
   localparam int IDX_W        = $clog2(NUM_PORTS)
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  limp_req_s [NUM_PORTS-1:0]   i_req,
   output limp_rsp_s [NUM_PORTS-1:0]   o_rsp,
   output limp_req_s                   o_req,
   input  limp_rsp_s                   i_rsp,
   output logic                        o_grant_valid,
   output logic [IDX_W-1:0]            o_grant_idx,
   output logic                        o_locked
);

   localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

   if (NUM_PORTS < 2 || NUM_PORTS > LIMP_MAX_PORTS) begin : g_bad_ports
      $error("NUM_PORTS out of range");
   end

   limp_arb_state_e      state, state_nxt;
   logic [IDX_W-1:0]     ptr, ptr_nxt;
   logic [IDX_W-1:0]     gnt, gnt_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [NUM_PORTS-1:0] req_vld;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   limp_req_s            own_req;

   function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
      return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_PORTS; k++) req_vld[k] = i_req[k].valid;
   end

   assign own_req = i_req[gnt];

   rr_prio_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req (req_vld),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      gnt_nxt       = gnt;
      cnt_nxt       = cnt;
      o_req         = '0;
      o_rsp         = '0;
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      o_locked      = 1'b0;
      unique case (state)
         LIMP_ARB_IDLE: begin
            if (pick_any) begin
               gnt_nxt   = pick_idx;
               state_nxt = LIMP_ARB_BUSY;
            end
         end
         LIMP_ARB_BUSY: begin
            o_grant_valid = 1'b1;
            o_grant_idx   = gnt;
            // A requester abandoning its request forfeits the slot.
            if (!own_req.valid) begin
               state_nxt = LIMP_ARB_IDLE;
               ptr_nxt   = next_port(gnt);
            end else begin
               o_req      = own_req;
               o_rsp[gnt] = i_rsp;
               if (i_rsp.ready) begin
                  ptr_nxt = next_port(gnt);
                  if (own_req.cmd == LIMP_AMO_READ && !i_rsp.illegal) begin
                     state_nxt = LIMP_ARB_LOCK;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = LIMP_ARB_IDLE;
                  end
               end
            end
         end
         LIMP_ARB_LOCK: begin
            o_grant_valid = 1'b1;
            o_grant_idx   = gnt;
            o_locked      = 1'b1;
            if (own_req.valid) begin
               state_nxt = LIMP_ARB_BUSY;
            end else begin
               cnt_nxt = cnt + 1'b1;
               if (LOCK_TIMEOUT != 0 && cnt == CNT_LAST) state_nxt = LIMP_ARB_IDLE;
            end
         end
         default: state_nxt = LIMP_ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= LIMP_ARB_IDLE;
         ptr   <= '0;
         gnt   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gnt   <= gnt_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         assert (!(state == LIMP_ARB_BUSY && !own_req.valid))
            else $error("granted requester dropped valid before ready");
         assert (!(i_rsp.ready && !o_req.valid))
            else $error("target ready with no request outstanding");
      end
   end

endmodule
